seq_chunk_adder: RTL
====================

Name: seq_chunk_adder

Overview:
- Parametrised, digit-serial successor to the 32-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, reusing one CHUNK-bit carry-chain slice.
- Uses valid/ready handshakes on input and output, so it can sit behind a register-file read stage or feed a result bus under backpressure.
- Trades latency for area: one shared CHUNK-bit adder instead of a WIDTH-bit chain.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle; must divide WIDTH exactly, 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode valid
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add) / borrow-in (sub)
- Sub  input  1  0 = A+B+Cin; 1 = A-B-Cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  result, registered
- Cout  output  1  carry-out of MSB; in subtract mode 1 means no borrow
- Ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (async assert, sync deassert-safe):
  - state = IDLE; in_ready = 1.
  - out_valid, S, Cout and Ovf all = 0.
  - Internal operand, carry and index registers are cleared.
- States:
  - IDLE: in_ready = 1, out_valid = 0. If in_valid at a clock edge, accept:
    - latch A.
    - latch Bx = Sub ? ~B : B.
    - carry = Sub ? ~Cin : Cin.
    - idx = 0; go to CALC.
  - CALC: in_ready = 0, out_valid = 0. Each edge does:
    - {c, sum} = A[idx chunk] + Bx[idx chunk] + carry (CHUNK+1-bit add).
    - Store sum into the idx chunk of the internal result register; carry = c.
    - idx++.
    - On the edge processing idx = NCHUNK-1, go to DONE and load S, Cout and Ovf.
  - DONE: out_valid = 1, in_ready = 0. On an edge with out_ready = 1, go to IDLE; out_valid drops the next cycle.
- Arithmetic:
  - Chunks are processed LSB first.
  - Subtract computes A + ~B + ~Cin, i.e. A - B - Cin mod 2^WIDTH.
  - Ovf = (A[WIDTH-1] == Bx[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]).
- Latency:
  - out_valid is high starting exactly NCHUNK edges after the accepting edge (4 for defaults).
  - Minimum issue interval is NCHUNK+2 cycles: accept, NCHUNK CALC edges, DONE handshake, return to IDLE.
- Output stability:
  - S, Cout and Ovf change only on the CALC→DONE transition.
  - They hold their values through DONE under backpressure and after returning to IDLE until the next result loads.
- Input handling:
  - A, B, Cin and Sub are sampled only on the accept edge; later changes have no effect.
  - in_valid outside IDLE is ignored; nothing is queued.
- Boundary conditions:
  - CHUNK == WIDTH: CALC lasts one cycle; latency is 1.
  - CHUNK == 1: fully bit-serial; latency = WIDTH.
  - out_ready high while not in DONE has no effect.
  - in_valid and out_ready both high in DONE: only the output handshake completes; the new input is accepted at the earliest on the following IDLE cycle.
  - rst_n low in any state, including mid-CALC: operation aborts immediately and all outputs take reset values; no partial result is ever presented.

Test Plan:
- Reset, then A=0xFFFFFFFF, B=0x00000001, Cin=0, Sub=0, in_valid for 1 cycle -> out_valid rises 4 edges after accept; S=0x00000000, Cout=1, Ovf=0; in_ready low from accept until return to IDLE.
- A=0x7FFFFFFF, B=0x00000001, Sub=0, Cin=0 -> S=0x80000000, Cout=0, Ovf=1; then A=0x12345678, B=0x0FEDCBA8, Cin=1 -> S=0x22222221, Cout=0, Ovf=0 (checks carry across all chunk boundaries).
- Sub=1, A=5, B=7, Cin=0 -> S=0xFFFFFFFE, Cout=0 (borrow), Ovf=0; Sub=1, A=0x80000000, B=1 -> S=0x7FFFFFFF, Cout=1, Ovf=1; Sub=1, A=10, B=3, Cin=1 -> S=6, Cout=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling A/B/in_valid -> S, Cout, Ovf and out_valid stable, in_ready=0, no new accept; raise out_ready -> IDLE next cycle, then next op accepted.
- Assert rst_n=0 asynchronously (mid-cycle) on the 2nd CALC cycle -> out_valid, S, Cout and Ovf go to 0 immediately and in_ready=1; after release, a fresh op 3+4 -> S=7 with normal latency.
- Rerun the first three scenarios with CHUNK=32 (latency 1), CHUNK=1 (latency 32) and WIDTH=16/CHUNK=4 (0xFFFF+1 -> S=0, Cout=1) -> results and latency match NCHUNK.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Digit-serial adder/subtractor: one shared CHUNK-bit carry slice walks the
// operands LSB first, with valid/ready handshakes on both sides.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, bx_q, res_q, s_q;
    logic             carry_q, cout_q, ovf_q;
    logic [IDXW-1:0]  idx_q;
    logic             in_ready_q, out_valid_q;

    logic [CHUNK:0]   sum_d;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             last_d;

    // The single CHUNK-bit slice; res_d is the result with the current chunk merged in.
    always_comb begin
        sum_d  = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, bx_q[idx_q*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};
        res_d  = res_q;
        res_d[idx_q*CHUNK +: CHUNK] = sum_d[CHUNK-1:0];
        ovf_d  = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
        last_d = (idx_q == IDXW'(NCHUNK - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            bx_q        <= '0;
            res_q       <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        bx_q       <= Sub ? ~B : B;
                        carry_q    <= Sub ? ~Cin : Cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    res_q   <= res_d;
                    carry_q <= sum_d[CHUNK];
                    idx_q   <= idx_q + 1'b1;
                    if (last_d) begin
                        s_q         <= res_d;
                        cout_q      <= sum_d[CHUNK];
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Outputs hold under backpressure; in_valid is ignored here.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
